// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared encodings for the UART echo bridge
// Rev 1.0
// ============================================================================
package uart_pkg;

   localparam logic [1:0] MODE_RAW      = 2'd0;
   localparam logic [1:0] MODE_UPPER    = 2'd1;
   localparam logic [1:0] MODE_DROP_ERR = 2'd2;
   localparam logic [1:0] MODE_SINK     = 2'd3;

   localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
   localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
   localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

   typedef enum logic [1:0] {
      T_IDLE  = 2'd0,
      T_ISSUE = 2'd1,
      T_BUSY  = 2'd2,
      T_DONE  = 2'd3
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// uart_sync_fifo : single-clock FIFO, extra-bit pointers, level output
// Rev 1.0
// ============================================================================
module uart_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int c_aw = $clog2(DEPTH);

   logic [c_aw:0]       r_wr_ptr;
   logic [c_aw:0]       r_rd_ptr;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic                w_do_push;
   logic                w_do_pop;

   assign empty = (r_wr_ptr == r_rd_ptr);
   // Same index but different lap bit means the writer is a full lap ahead.
   assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                  (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   assign level = r_wr_ptr - r_rd_ptr;

   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   assign pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/uart_echo_bridge.sv
`default_nettype none
// ============================================================================
// uart_echo_bridge : buffered rx->tx echo with byte modes, overflow count, LEDs
// Rev 1.0
// ============================================================================
module uart_echo_bridge
   import uart_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int LED_STRETCH    = 2_700_000,
   parameter int HEARTBEAT_HALF = 13_500_000,
   parameter int LED_ACTIVE_LOW = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           rx_done,
   input  logic [DATA_W-1:0]              rx_data,
   input  logic                           rx_parity_err,
   input  logic                           rx_framing_err,
   output logic                           rx_ack,
   input  logic                           tx_ready,
   output logic                           tx_valid,
   output logic [DATA_W-1:0]              tx_data,
   input  logic [1:0]                     mode,
   input  logic                           err_clr,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic [7:0]                     overflow_cnt,
   output logic                           led_heartbeat,
   output logic                           led_rx,
   output logic                           led_tx,
   output logic                           led_err
);

   localparam int c_str_w = $clog2(LED_STRETCH + 1);
   localparam int c_hb_w  = $clog2(HEARTBEAT_HALF + 1);
   localparam logic [c_str_w-1:0] c_stretch = c_str_w'(LED_STRETCH);
   localparam logic [c_hb_w-1:0]  c_hb_last = c_hb_w'(HEARTBEAT_HALF - 1);
   localparam logic               c_led_pol = (LED_ACTIVE_LOW != 0);
   localparam logic [DATA_W-1:0]  c_lower_a = DATA_W'(ASCII_LOWER_A);
   localparam logic [DATA_W-1:0]  c_lower_z = DATA_W'(ASCII_LOWER_Z);
   localparam logic [DATA_W-1:0]  c_case_off = DATA_W'(ASCII_CASE_OFFSET);

   logic                r_rx_ack;
   logic                r_rx_hold;
   logic                w_rx_err;
   logic                w_keep;
   logic [DATA_W-1:0]   w_push_data;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_overflow;
   logic [DATA_W-1:0]   w_fifo_head;

   tx_state_t           r_state;
   logic                r_tx_valid;
   logic [DATA_W-1:0]   r_tx_data;

   logic [7:0]          r_ovf_cnt;
   logic                r_err;
   logic                w_err_nxt;
   logic [c_str_w-1:0]  r_rx_cnt;
   logic [c_str_w-1:0]  r_tx_cnt;
   logic [c_str_w-1:0]  w_rx_cnt_nxt;
   logic [c_str_w-1:0]  w_tx_cnt_nxt;
   logic [c_hb_w-1:0]   r_hb_cnt;
   logic                r_led_hb;
   logic                r_led_rx;
   logic                r_led_tx;
   logic                r_led_err;

   // r_rx_hold blocks a second ack until uart_rx has dropped rx_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_ack  <= 1'b0;
         r_rx_hold <= 1'b0;
      end else begin
         r_rx_ack <= rx_done & ~r_rx_ack & ~r_rx_hold;
         if (r_rx_ack)      r_rx_hold <= 1'b1;
         else if (!rx_done) r_rx_hold <= 1'b0;
      end
   end

   assign w_rx_err = rx_parity_err | rx_framing_err;

   always_comb begin
      w_push_data = rx_data;
      w_keep      = 1'b0;
      case (mode)
         MODE_RAW:      w_keep = 1'b1;
         MODE_UPPER: begin
            w_keep = 1'b1;
            if (rx_data >= c_lower_a && rx_data <= c_lower_z)
               w_push_data = rx_data - c_case_off;
         end
         MODE_DROP_ERR: w_keep = ~w_rx_err;
         default:       w_keep = 1'b0;
      endcase
   end

   assign w_push     = r_rx_ack & w_keep;
   assign w_pop      = (r_state == T_IDLE) & ~w_empty & tx_ready;
   assign w_overflow = w_push & w_full & ~w_pop;

   uart_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .pop_data  (w_fifo_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= T_IDLE;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_tx_valid <= 1'b0;
         case (r_state)
            T_IDLE: begin
               if (w_pop) begin
                  r_tx_data <= w_fifo_head;
                  r_state   <= T_ISSUE;
               end
            end
            T_ISSUE: begin
               r_tx_valid <= 1'b1;
               r_state    <= T_BUSY;
            end
            T_BUSY:  if (!tx_ready) r_state <= T_DONE;
            T_DONE:  if (tx_ready)  r_state <= T_IDLE;
            default: r_state <= T_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ovf_cnt <= '0;
      else if (w_overflow && r_ovf_cnt != 8'hFF)
         r_ovf_cnt <= r_ovf_cnt + 1'b1;
   end

   // A set arriving with a clear wins so no error is silently lost.
   assign w_err_nxt = (r_rx_ack & w_rx_err) ? 1'b1 :
                      (err_clr ? 1'b0 : r_err);

   assign w_rx_cnt_nxt = r_rx_ack   ? c_stretch :
                         ((r_rx_cnt != '0) ? r_rx_cnt - 1'b1 : '0);
   assign w_tx_cnt_nxt = r_tx_valid ? c_stretch :
                         ((r_tx_cnt != '0) ? r_tx_cnt - 1'b1 : '0);

   // LED pins reset to the lit level as a lamp test.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err     <= 1'b0;
         r_rx_cnt  <= '0;
         r_tx_cnt  <= '0;
         r_hb_cnt  <= '0;
         r_led_hb  <= ~c_led_pol;
         r_led_rx  <= ~c_led_pol;
         r_led_tx  <= ~c_led_pol;
         r_led_err <= ~c_led_pol;
      end else begin
         r_err     <= w_err_nxt;
         r_rx_cnt  <= w_rx_cnt_nxt;
         r_tx_cnt  <= w_tx_cnt_nxt;
         r_led_rx  <= (w_rx_cnt_nxt != '0) ^ c_led_pol;
         r_led_tx  <= (w_tx_cnt_nxt != '0) ^ c_led_pol;
         r_led_err <= w_err_nxt ^ c_led_pol;
         if (r_hb_cnt == c_hb_last) begin
            r_hb_cnt <= '0;
            r_led_hb <= ~r_led_hb;
         end else begin
            r_hb_cnt <= r_hb_cnt + 1'b1;
         end
      end
   end

   assign rx_ack        = r_rx_ack;
   assign tx_valid      = r_tx_valid;
   assign tx_data       = r_tx_data;
   assign overflow_cnt  = r_ovf_cnt;
   assign led_heartbeat = r_led_hb;
   assign led_rx        = r_led_rx;
   assign led_tx        = r_led_tx;
   assign led_err       = r_led_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_bridge.sv
`default_nettype none
// ============================================================================
// tb_uart_echo_bridge : directed stimulus with a tx scoreboard
// Rev 1.0
// ============================================================================
module tb_uart_echo_bridge;

   localparam int STRETCH = 8;
   localparam int HB_HALF = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_done, rx_parity_err, rx_framing_err, rx_ack;
   logic [7:0] rx_data;
   logic       tx_ready, tx_valid;
   logic [7:0] tx_data;
   logic [1:0] mode;
   logic       err_clr;
   logic [4:0] fifo_level;
   logic [7:0] overflow_cnt;
   logic       led_heartbeat, led_rx, led_tx, led_err;

   logic       tx_hold;
   int         tx_busy = 0;
   int         cyc = 0;
   int         n_vec = 0, n_miss = 0;
   int         n_tx = 0, n_acks = 0, last_tx_cyc = 0, ack_cyc = 0;
   int         rx_on = 0, tx_on = 0;
   logic       saw_busy = 1'b0;
   logic [7:0] sb [$];

   uart_echo_bridge #(
      .DATA_W         (8),
      .FIFO_DEPTH     (16),
      .LED_STRETCH    (STRETCH),
      .HEARTBEAT_HALF (HB_HALF),
      .LED_ACTIVE_LOW (1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_done        (rx_done),
      .rx_data        (rx_data),
      .rx_parity_err  (rx_parity_err),
      .rx_framing_err (rx_framing_err),
      .rx_ack         (rx_ack),
      .tx_ready       (tx_ready),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .mode           (mode),
      .err_clr        (err_clr),
      .fifo_level     (fifo_level),
      .overflow_cnt   (overflow_cnt),
      .led_heartbeat  (led_heartbeat),
      .led_rx         (led_rx),
      .led_tx         (led_tx),
      .led_err        (led_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx stand-in: busy for 4 cycles after each start pulse
   always @(posedge clk) begin
      if (tx_valid)         tx_busy <= 4;
      else if (tx_busy > 0) tx_busy <= tx_busy - 1;
   end
   assign tx_ready = ~tx_hold & (tx_busy == 0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && rx_ack) n_acks++;
      if (rst_n && !led_rx) rx_on++;
      if (rst_n && !led_tx) tx_on++;
      if (!tx_ready) saw_busy = 1'b1;
      if (rst_n && tx_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_tx: got 0x%02h, required no transmission", tx_data);
         end else begin
            check("tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
         end
         if (n_tx > 0)
            check("tx_gap_busy", {31'd0, (cyc - last_tx_cyc >= 4) && saw_busy}, 32'd1);
         saw_busy    = 1'b0;
         last_tx_cyc = cyc;
         n_tx++;
      end
   end

   task automatic send(input logic [7:0] d, input logic pe, input logic fe,
                       input logic clr, input logic exp_en, input logic [7:0] exp_d);
      int t;
      if (exp_en) sb.push_back(exp_d);
      @(posedge clk); #1;
      rx_data = d; rx_parity_err = pe; rx_framing_err = fe; err_clr = clr; rx_done = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (rx_ack !== 1'b1 && t < 20);
      check("rx_ack_seen", {31'd0, rx_ack}, 32'd1);
      ack_cyc = cyc;
      @(posedge clk); #1;
      rx_done = 1'b0; rx_parity_err = 1'b0; rx_framing_err = 1'b0; err_clr = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sb.size() != 0 || fifo_level != 0) && t < 600) begin
         @(negedge clk);
         t++;
      end
      repeat (12) @(negedge clk);
      check("drain_queue", sb.size(), 32'd0);
      check("drain_level", {27'd0, fifo_level}, 32'd0);
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int base_rx, base_tx, base_ack, base_n, t;
      rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; rx_parity_err = 1'b0;
      rx_framing_err = 1'b0; mode = 2'd0; err_clr = 1'b0; tx_hold = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_level", {27'd0, fifo_level}, 32'd0);
      check("rst_ovf", {24'd0, overflow_cnt}, 32'd0);
      check("rst_leds", {28'd0, led_heartbeat, led_rx, led_tx, led_err}, 32'd0);

      @(posedge clk); #1 rst_n = 1'b1;
      repeat (HB_HALF) @(negedge clk);
      check("hb_still_on", {31'd0, led_heartbeat}, 32'd0);
      check("led_err_off", {31'd0, led_err}, 32'd1);
      @(negedge clk);
      check("hb_first_toggle", {31'd0, led_heartbeat}, 32'd1);

      // raw loopback: latency, single ack, stretched activity LEDs
      base_rx = rx_on; base_tx = tx_on; base_ack = n_acks; base_n = n_tx;
      send(8'h41, 0, 0, 0, 1, 8'h41);
      t = 0;
      while (n_tx == base_n && t < 20) begin @(negedge clk); t++; end
      check("latency", last_tx_cyc - ack_cyc, 32'd3);
      repeat (30) @(negedge clk);
      check("single_ack", n_acks - base_ack, 32'd1);
      check("led_rx_stretch", rx_on - base_rx, STRETCH);
      check("led_tx_stretch", tx_on - base_tx, STRETCH);

      // uppercase echo, including the values just outside a..z
      @(posedge clk); #1 mode = 2'd1;
      send(8'h61, 0, 0, 0, 1, 8'h41);
      send(8'h7A, 0, 0, 0, 1, 8'h5A);
      send(8'h7B, 0, 0, 0, 1, 8'h7B);
      send(8'h5A, 0, 0, 0, 1, 8'h5A);
      send(8'h60, 0, 0, 0, 1, 8'h60);
      send(8'h6D, 1, 0, 0, 1, 8'h4D);
      drain();
      pulse_clr();
      check("err_cleared_m1", {31'd0, led_err}, 32'd1);

      // drop-on-error, sticky error LED and its clear
      @(posedge clk); #1 mode = 2'd2;
      send(8'h11, 1, 0, 0, 0, 8'h00);
      send(8'h22, 0, 0, 0, 1, 8'h22);
      send(8'h33, 0, 1, 0, 0, 8'h00);
      drain();
      check("led_err_set", {31'd0, led_err}, 32'd0);
      pulse_clr();
      check("led_err_clr", {31'd0, led_err}, 32'd1);
      send(8'h44, 1, 0, 1, 0, 8'h00);
      repeat (2) @(negedge clk);
      check("err_set_wins", {31'd0, led_err}, 32'd0);
      pulse_clr();

      // sink: nothing transmitted, errors still flagged
      @(posedge clk); #1 mode = 2'd3;
      base_n = n_tx;
      send(8'h55, 0, 0, 0, 0, 8'h00);
      send(8'h66, 0, 1, 0, 0, 8'h00);
      drain();
      check("sink_no_tx", n_tx - base_n, 32'd0);
      check("sink_err", {31'd0, led_err}, 32'd0);
      pulse_clr();

      // overflow: 19 bytes into a stalled 16-entry FIFO
      @(posedge clk); #1 mode = 2'd0; tx_hold = 1'b1;
      for (int i = 0; i < 19; i++)
         send(8'h80 + 8'(i), 0, 0, 0, i < 16, 8'h80 + 8'(i));
      repeat (2) @(negedge clk);
      check("full_level", {27'd0, fifo_level}, 32'd16);
      check("ovf_three", {24'd0, overflow_cnt}, 32'd3);
      @(posedge clk); #1 tx_hold = 1'b0;
      drain();

      // saturation: refill then 300 more
      @(posedge clk); #1 tx_hold = 1'b1;
      for (int i = 0; i < 16; i++)
         send(8'hA0 + 8'(i), 0, 0, 0, 1, 8'hA0 + 8'(i));
      for (int i = 0; i < 251; i++)
         send(8'(i), 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      check("ovf_254", {24'd0, overflow_cnt}, 32'd254);
      for (int i = 0; i < 49; i++)
         send(8'(i), 0, 0, 0, 0, 8'h00);
      @(negedge clk);
      check("ovf_saturated", {24'd0, overflow_cnt}, 32'd255);
      check("sat_level", {27'd0, fifo_level}, 32'd16);
      @(posedge clk); #1 tx_hold = 1'b0;
      drain();
      check("tx_data_before_rst", {24'd0, tx_data}, 32'h000000AF);

      // reset with 5 bytes queued
      @(posedge clk); #1 tx_hold = 1'b1;
      for (int i = 0; i < 5; i++)
         send(8'h31 + 8'(i), 0, 0, 0, 1, 8'h31 + 8'(i));
      @(negedge clk);
      check("five_queued", {27'd0, fifo_level}, 32'd5);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_level", {27'd0, fifo_level}, 32'd0);
      check("mid_rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("mid_rst_ovf", {24'd0, overflow_cnt}, 32'd0);
      check("mid_rst_leds", {28'd0, led_heartbeat, led_rx, led_tx, led_err}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1; tx_hold = 1'b0;
      base_n = n_tx;
      repeat (30) @(negedge clk);
      check("no_tx_after_rst", n_tx - base_n, 32'd0);
      send(8'h5A, 0, 0, 0, 1, 8'h5A);
      drain();
      check("tx_after_rst", n_tx - base_n, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_echo_bridge.md
Name: uart_echo_bridge

Overview:
Parametrised loopback/echo controller placed between uart_rx and uart_tx in the board top level. It supersedes the single-register direct loopback with:
- a synchronous byte FIFO that decouples receive from transmit;
- selectable per-byte processing modes;
- overflow accounting;
- stretched, polarity-configurable status LEDs with a clearable sticky error indicator.

Parameters:
DATA_W, 8, byte width on rx/tx data paths
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
LED_STRETCH, 2_700_000, cycles an activity LED stays on after an event (100 ms at 27 MHz)
HEARTBEAT_HALF, 13_500_000, cycles per heartbeat half-period
LED_ACTIVE_LOW, 1, 1 = LED pins drive 0 for "on"

Ports:
clk  in  1  system clock
rst_n  in  1  reset
rx_done  in  1  uart_rx byte ready; level, held until rx_ack
rx_data  in  DATA_W  received byte, valid while rx_done
rx_parity_err  in  1  parity error for current byte, valid while rx_done
rx_framing_err  in  1  framing error for current byte, valid while rx_done
rx_ack  out  1  one-cycle accept pulse to uart_rx
tx_ready  in  1  uart_tx idle
tx_valid  out  1  one-cycle start pulse to uart_tx
tx_data  out  DATA_W  byte to transmit, registered
mode  in  2  0 raw loopback, 1 uppercase echo, 2 drop-on-error, 3 sink (no tx)
err_clr  in  1  clears sticky error, synchronous pulse
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow_cnt  out  8  saturating count of bytes dropped because the FIFO was full
led_heartbeat, led_rx, led_tx, led_err  out  1 each  status LEDs

Behaviour:
- Reset is rst_n, asynchronous, active-low; the block runs on clock clk.
- Reset values:
  - rx_ack=0, tx_valid=0, tx_data=0, fifo_level=0, overflow_cnt=0.
  - All four LEDs at the "on" level (lamp test).
  - FIFO emptied; TX FSM in T_IDLE.
- Reset mid-transfer discards FIFO contents. Any byte already handed to uart_tx completes under uart_tx control.
- RX accept:
  - When rx_done=1 and rx_ack was 0 the previous cycle, pulse rx_ack for exactly one cycle.
  - Never two acks for one rx_done assertion.
  - Mode is sampled on the accept cycle.
- Processing at accept:
  - mode 0: push the byte unchanged.
  - mode 1: 0x61..0x7A minus 0x20 before push; all other bytes unchanged.
  - mode 2: push only if both error flags are 0; otherwise discard.
  - mode 3: discard.
  - Errored bytes are pushed in modes 0 and 1.
- FIFO full:
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is acked and dropped, and overflow_cnt increments, saturating at 255.
- TX FSM:
  - T_IDLE: if FIFO non-empty and tx_ready=1, pop the head into tx_data and go to T_ISSUE.
  - T_ISSUE: tx_valid=1 for one cycle, then T_BUSY.
  - T_BUSY: wait for tx_ready=0, then T_DONE.
  - T_DONE: wait for tx_ready=1, then T_IDLE.
  - tx_data stays stable from T_ISSUE until the next pop.
  - Minimum gap between tx_valid pulses is 4 cycles.
- Latency: for an empty FIFO and tx_ready=1, tx_valid asserts 3 cycles after the rx_ack cycle (push, pop/register, issue).
- fifo_level is updated the cycle after each push/pop. A simultaneous push and pop leaves it unchanged.
- Error LED:
  - Sticky flag sets on an accepted byte with either error flag, in every mode.
  - err_clr clears it; when set and clear coincide, set wins.
  - led_err reflects the flag.
- Activity LEDs:
  - led_rx is on for LED_STRETCH cycles after each rx_ack; led_tx likewise after each tx_valid.
  - A new event retriggers the counter to full.
- Heartbeat: led_heartbeat toggles every HEARTBEAT_HALF cycles; after reset it leaves reset "on" and first toggles HEARTBEAT_HALF cycles later.
- Polarity: every LED output = logical state XOR LED_ACTIVE_LOW.

Decomposition:
- Package uart_pkg holds:
  - mode encodings MODE_RAW, MODE_UPPER, MODE_DROP_ERR, MODE_SINK;
  - the TX FSM state enum;
  - ASCII constants 0x61, 0x7A, 0x20.
- One sub-module, uart_sync_fifo, parametrised DATA_W/DEPTH:
  - push/pop/full/empty/level;
  - extra-bit pointers handle wrap-around;
  - pop-when-empty and push-when-full-without-pop are ignored internally.
- LED stretch counters are inline.

Test Plan:
- Mode 0, tx_ready tied high, send 0x41: one rx_ack pulse; tx_valid 3 cycles later with tx_data=0x41; led_rx and led_tx on for LED_STRETCH cycles.
- Mode 1, send 0x61, 0x7A, 0x7B, 0x5A: transmitted order is 0x41, 0x5A, 0x7B, 0x5A.
- Mode 2, send 0x11 with parity_err=1, then 0x22 clean: only 0x22 transmitted; led_err on; err_clr pulse turns it off; err_clr coinciding with a new error leaves it on.
- Hold tx_ready=0, send FIFO_DEPTH+3 bytes:
  - fifo_level=16 and overflow_cnt=3;
  - release tx_ready: the first 16 bytes come out in order, each tx_valid separated by a full busy/ready cycle.
- Push 300 bytes into a full FIFO: overflow_cnt saturates at 255.
- Assert rst_n low with 5 bytes queued: outputs return to reset values immediately, and there is no tx_valid after release until new rx_done.
